// File: rtl/tsc_mem_pkg.sv
// Shared types and default sizing for the TSC memory responder.
package tsc_mem_pkg;

  localparam int TSC_WORD_SIZE   = 16;
  localparam int TSC_MEMORY_SIZE = 256;
  localparam int TSC_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/tsc_mem_responder_if.sv
// CPU-side memory bus plus the program-load side port.
interface tsc_mem_responder_if
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE = TSC_WORD_SIZE
) ();

  logic                 read_m;
  logic                 write_m;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] write_data;
  logic [WORD_SIZE-1:0] read_data;
  logic                 input_ready;
  logic                 busy;
  logic                 addr_err;
  logic                 load_we;
  logic [WORD_SIZE-1:0] load_addr;
  logic [WORD_SIZE-1:0] load_data;

  modport master (
    output read_m, write_m, address, write_data, load_we, load_addr, load_data,
    input  read_data, input_ready, busy, addr_err
  );

  modport slave (
    input  read_m, write_m, address, write_data, load_we, load_addr, load_data,
    output read_data, input_ready, busy, addr_err
  );

endinterface

// File: rtl/tsc_mem_array.sv
// Single-write-port word storage with a registered, resettable read result.
module tsc_mem_array
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE   = TSC_WORD_SIZE,
  parameter int MEMORY_SIZE = TSC_MEMORY_SIZE,
  parameter int ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  // Contents deliberately survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)   rdata <= '0;
    else if (rd_en) rdata <= rd_zero ? '0 : mem[raddr];
  end

endmodule

// File: rtl/tsc_mem_responder.sv
// Fixed-latency memory responder: FSM, latency counter, range check and write-port mux.
module tsc_mem_responder
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE   = TSC_WORD_SIZE,
  parameter int MEMORY_SIZE = TSC_MEMORY_SIZE,
  parameter int LATENCY     = TSC_LATENCY
) (
  input logic               clk,
  input logic               reset_n,
  tsc_mem_responder_if.slave bus
);

  localparam int ADDR_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(LATENCY - 1);
  localparam logic [WORD_SIZE:0] MEM_LIMIT = (WORD_SIZE + 1)'(MEMORY_SIZE);

  function automatic logic in_range(input logic [WORD_SIZE-1:0] a);
    return {1'b0, a} < MEM_LIMIT;
  endfunction

  mem_state_t           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 op_write;
  logic [WORD_SIZE-1:0] lat_addr, lat_data;
  logic                 accept, enter_resp;
  logic                 acc_write, acc_ok, load_ok;
  logic [WORD_SIZE-1:0] acc_addr, acc_data;
  logic                 rdy_q, err_q;
  logic                 arr_we;
  logic [ADDR_W-1:0]    arr_waddr;
  logic [WORD_SIZE-1:0] arr_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdy_q <= enter_resp;
      err_q <= enter_resp && !acc_ok;
      if (accept) begin
        op_write <= bus.write_m;
        lat_addr <= bus.address;
        lat_data <= bus.write_data;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read_m ^ bus.write_m) begin
          accept = 1'b1;
          cnt_n  = CNT_INIT;
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY=1 the access completes on the accept edge, so it must use the live request.
  always_comb begin
    acc_write = (state == IDLE) ? bus.write_m    : op_write;
    acc_addr  = (state == IDLE) ? bus.address    : lat_addr;
    acc_data  = (state == IDLE) ? bus.write_data : lat_data;
    acc_ok    = in_range(acc_addr);
    load_ok   = (state == IDLE) && !bus.read_m && !bus.write_m &&
                bus.load_we && in_range(bus.load_addr);
    arr_we    = reset_n && ((enter_resp && acc_write && acc_ok) || load_ok);
    arr_waddr = load_ok ? bus.load_addr[ADDR_W-1:0] : acc_addr[ADDR_W-1:0];
    arr_wdata = load_ok ? bus.load_data : acc_data;
  end

  tsc_mem_array #(
    .WORD_SIZE  (WORD_SIZE),
    .MEMORY_SIZE(MEMORY_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (arr_we),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .rd_en  (enter_resp && !acc_write),
    .rd_zero(!acc_ok),
    .raddr  (acc_addr[ADDR_W-1:0]),
    .rdata  (bus.read_data)
  );

  assign bus.input_ready = rdy_q;
  assign bus.addr_err    = err_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_tsc_mem_responder.sv
// Scoreboard bench driving three responders with LATENCY 2, 3 and 1.
module tb_tsc_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        rd[3], wr[3], lwe[3];
  logic [15:0] addr[3], wdat[3], laddr[3], ldat[3];
  logic [15:0] rdata[3];
  logic        rdy[3], bsy[3], err[3];

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[3][256];
  logic [15:0] last_rd[3];
  int          checks   = 0;
  int          failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    tsc_mem_responder_if #(.WORD_SIZE(16)) bus ();
    assign bus.read_m     = rd[g];
    assign bus.write_m    = wr[g];
    assign bus.address    = addr[g];
    assign bus.write_data = wdat[g];
    assign bus.load_we    = lwe[g];
    assign bus.load_addr  = laddr[g];
    assign bus.load_data  = ldat[g];
    assign rdata[g]       = bus.read_data;
    assign rdy[g]         = bus.input_ready;
    assign bsy[g]         = bus.busy;
    assign err[g]         = bus.addr_err;
    tsc_mem_responder #(
      .WORD_SIZE  (16),
      .MEMORY_SIZE(256),
      .LATENCY    (LAT)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
  end

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 3 : 1);
  endfunction

  function automatic logic [15:0] img(input int unsigned a);
    logic [15:0] v;
    v = 16'(a) ^ 16'd5;
    return 16'h6101 ^ (v * 16'h0111);
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic load_word(input int idx, input logic [15:0] a, input logic [15:0] d);
    lwe[idx] = 1'b1; laddr[idx] = a; ldat[idx] = d;
    next_cycle();
    lwe[idx] = 1'b0;
    if (a < 16'd256) model[idx][a[7:0]] = d;
  endtask

  task automatic access(input int idx, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic load_mid);
    int   lat;
    bit   seen;
    exp_t e;
    logic e_err;
    lat  = lat_of(idx);
    seen = 0;
    rd[idx] = !w; wr[idx] = w; addr[idx] = a; wdat[idx] = d;
    e.err = (a >= 16'd256);
    if (w) begin
      e.data = last_rd[idx];
      if (a < 16'd256) model[idx][a[7:0]] = d;
    end else begin
      e.data = (a < 16'd256) ? model[idx][a[7:0]] : 16'h0000;
      last_rd[idx] = e.data;
    end
    e_err = e.err;
    sb.push_back(e);
    for (int k = 1; k <= lat + 2 && !seen; k++) begin
      next_cycle();
      if (k == 1) begin
        addr[idx] = a ^ 16'h00FF;
        wdat[idx] = ~d;
        if (load_mid) begin
          lwe[idx] = 1'b1; laddr[idx] = 16'd6; ldat[idx] = 16'h1234;
        end
      end
      if (k == 2) lwe[idx] = 1'b0;
      checks++;
      if (bsy[idx] !== (k <= lat)) begin
        failures++;
        $display("FAIL busy dut=%0d cycle=%0d got=%b want=%b", idx, k, bsy[idx], (k <= lat));
      end
      checks++;
      if (rdy[idx] !== (k == lat)) begin
        failures++;
        $display("FAIL input_ready dut=%0d cycle=%0d got=%b want=%b", idx, k, rdy[idx], (k == lat));
      end
      checks++;
      if (err[idx] !== ((k == lat) && e_err)) begin
        failures++;
        $display("FAIL addr_err dut=%0d cycle=%0d got=%b want=%b", idx, k, err[idx], ((k == lat) && e_err));
      end
      if (w) begin
        checks++;
        if (rdata[idx] !== last_rd[idx]) begin
          failures++;
          $display("FAIL read_data_hold dut=%0d cycle=%0d got=%h want=%h", idx, k, rdata[idx], last_rd[idx]);
        end
      end
      if (rdy[idx] === 1'b1) begin
        seen = 1;
        e = sb.pop_front();
        checks++;
        if (rdata[idx] !== e.data) begin
          failures++;
          $display("FAIL read_data dut=%0d addr=%h got=%h want=%h", idx, a, rdata[idx], e.data);
        end
        rd[idx] = 1'b0; wr[idx] = 1'b0;
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL timeout dut=%0d addr=%h got=no_ready want=ready", idx, a);
      rd[idx] = 1'b0; wr[idx] = 1'b0;
      sb.delete();
    end
    lwe[idx] = 1'b0;
    next_cycle();
    checks++;
    if (bsy[idx] !== 1'b0 || rdy[idx] !== 1'b0) begin
      failures++;
      $display("FAIL idle_after dut=%0d got=%b%b want=00", idx, bsy[idx], rdy[idx]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdata[i] !== 16'h0000) begin failures++; $display("FAIL reset_read_data dut=%0d got=%h want=0000", i, rdata[i]); end
      checks++;
      if (rdy[i] !== 1'b0) begin failures++; $display("FAIL reset_ready dut=%0d got=%b want=0", i, rdy[i]); end
      checks++;
      if (bsy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy dut=%0d got=%b want=0", i, bsy[i]); end
      checks++;
      if (err[i] !== 1'b0) begin failures++; $display("FAIL reset_addr_err dut=%0d got=%b want=0", i, err[i]); end
      last_rd[i] = 16'h0000;
    end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic load_image();
    for (int i = 0; i < 3; i++)
      for (int unsigned a = 0; a < 8; a++) load_word(i, 16'(a), img(a));
  endtask

  task automatic test_load_read();
    access(0, 1'b0, 16'd5, 16'h0000, 1'b0);
  endtask

  task automatic test_write_read();
    access(1, 1'b0, 16'd2, 16'h0000, 1'b0);
    access(1, 1'b1, 16'd7, 16'hBEEF, 1'b0);
    access(1, 1'b0, 16'd7, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   got;
    got = 0;
    rd[2] = 1'b1; wr[2] = 1'b0; addr[2] = 16'd0;
    e.data = model[2][0]; e.err = 1'b0; sb.push_back(e);
    for (int k = 1; k <= 8 && got < 3; k++) begin
      next_cycle();
      checks++;
      if (rdy[2] !== ((k % 2) == 1)) begin
        failures++;
        $display("FAIL b2b_ready cycle=%0d got=%b want=%b", k, rdy[2], ((k % 2) == 1));
      end
      checks++;
      if (bsy[2] !== ((k % 2) == 1)) begin
        failures++;
        $display("FAIL b2b_busy cycle=%0d got=%b want=%b", k, bsy[2], ((k % 2) == 1));
      end
      if (rdy[2] === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (rdata[2] !== e.data) begin
          failures++;
          $display("FAIL b2b_read_data n=%0d got=%h want=%h", got, rdata[2], e.data);
        end
        last_rd[2] = e.data;
        got++;
        if (got < 3) begin
          addr[2] = 16'(got);
          e.data = model[2][got]; e.err = 1'b0; sb.push_back(e);
        end else begin
          rd[2] = 1'b0;
        end
      end
    end
    rd[2] = 1'b0;
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=3", got);
    end
    sb.delete();
    next_cycle();
  endtask

  task automatic test_addr_err();
    access(0, 1'b0, 16'h0100, 16'h0000, 1'b0);
    access(0, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    load_word(0, 16'h0105, 16'h5555);
    access(0, 1'b0, 16'd5, 16'h0000, 1'b0);
  endtask

  task automatic test_both_high();
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'd4; wdat[0] = 16'hFFFF;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      checks++;
      if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
        failures++;
        $display("FAIL both_high cycle=%0d got=%b%b want=00", k, bsy[0], rdy[0]);
      end
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    next_cycle();
    access(0, 1'b0, 16'd4, 16'h0000, 1'b0);
  endtask

  task automatic test_load_while_busy();
    access(0, 1'b0, 16'd2, 16'h0000, 1'b1);
    access(0, 1'b0, 16'd6, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'd3; wdat[1] = 16'hAAAA;
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
    wr[1] = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdata[i] !== 16'h0000 || rdy[i] !== 1'b0 || bsy[i] !== 1'b0 || err[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid dut=%0d got=%h/%b/%b/%b want=0000/0/0/0", i, rdata[i], rdy[i], bsy[i], err[i]);
      end
      last_rd[i] = 16'h0000;
    end
    reset_n = 1'b1;
    next_cycle();
    access(1, 1'b0, 16'd3, 16'h0000, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; lwe[i] = 1'b0;
      addr[i] = '0; wdat[i] = '0; laddr[i] = '0; ldat[i] = '0;
      last_rd[i] = '0;
    end
    test_reset();
    load_image();
    test_load_read();
    test_write_read();
    test_back_to_back();
    test_addr_err();
    test_both_high();
    test_load_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
